// File: rtl/dot_pkg.sv
`default_nettype none
// ============================================================================
// dot_pkg : types and constants shared by weight_loader and the dot engine
// Revision: 1.0
// ============================================================================
package dot_pkg;

  localparam int DATA_W       = 32;
  localparam int DEFAULT_ROWS = 3;
  localparam int DEFAULT_COLS = 4;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } wl_state_e;

  // Index counters never shrink below one bit, even for a single row/column.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// weight_loader : double-buffered AXI-Stream weight matrix loader
// Revision: 1.0
// ============================================================================
module weight_loader
  import dot_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_W-1:0]                      WEIGHT_AXIS_TDATA,
  input  logic                                   WEIGHT_AXIS_TLAST,
  input  logic                                   WEIGHT_AXIS_TVALID,
  output logic                                   WEIGHT_AXIS_TREADY,
  input  logic                                   weights_lock,
  output logic [0:ROWS-1][0:COLS-1][DATA_W-1:0]  weights,
  output logic                                   weights_valid,
  output logic                                   weights_updated,
  output logic                                   load_error
);

  localparam int RW = idx_width(ROWS);
  localparam int CW = idx_width(COLS);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  typedef logic [0:ROWS-1][0:COLS-1][DATA_W-1:0] mat_t;

  wl_state_e     state_q,   state_d;
  logic [RW-1:0] r_q,       r_d;
  logic [CW-1:0] c_q,       c_d;
  mat_t          shadow_q,  shadow_d;
  mat_t          weights_q, weights_d;
  logic          valid_q,   valid_d;
  logic          updated_q, updated_d;
  logic          error_q,   error_d;

  logic          beat_ok;
  logic          at_last;

  assign beat_ok = WEIGHT_AXIS_TVALID && WEIGHT_AXIS_TREADY;
  assign at_last = (r_q == R_LAST) && (c_q == C_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (beat_ok && at_last) begin
          state_d = WEIGHT_AXIS_TLAST ? ST_COMMIT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat_ok && WEIGHT_AXIS_TLAST) begin
          state_d = ST_FILL;
        end
      end
      ST_COMMIT: begin
        if (!weights_lock) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Ready is held low through reset, not just gated by the reset state.
  always_comb begin
    WEIGHT_AXIS_TREADY = rst && (state_q != ST_COMMIT);
  end

  // Index counters, shadow fill and commit
  always_comb begin
    r_d       = r_q;
    c_d       = c_q;
    shadow_d  = shadow_q;
    weights_d = weights_q;
    valid_d   = valid_q;
    updated_d = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (beat_ok) begin
          shadow_d[r_q][c_q] = WEIGHT_AXIS_TDATA;
          if (WEIGHT_AXIS_TLAST && !at_last) begin
            error_d = 1'b1;
            r_d     = '0;
            c_d     = '0;
          end else if (!WEIGHT_AXIS_TLAST && at_last) begin
            error_d = 1'b1;
          end else if (!at_last) begin
            if (c_q == C_LAST) begin
              c_d = '0;
              r_d = r_q + 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (beat_ok && WEIGHT_AXIS_TLAST) begin
          r_d = '0;
          c_d = '0;
        end
      end
      ST_COMMIT: begin
        if (!weights_lock) begin
          weights_d = shadow_q;
          valid_d   = 1'b1;
          updated_d = 1'b1;
          r_d       = '0;
          c_d       = '0;
        end
      end
      default: begin
        r_d = '0;
        c_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      c_q       <= '0;
      shadow_q  <= '0;
      weights_q <= '0;
      valid_q   <= 1'b0;
      updated_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      r_q       <= r_d;
      c_q       <= c_d;
      shadow_q  <= shadow_d;
      weights_q <= weights_d;
      valid_q   <= valid_d;
      updated_q <= updated_d;
      error_q   <= error_d;
    end
  end

  assign weights         = weights_q;
  assign weights_valid   = valid_q;
  assign weights_updated = updated_q;
  assign load_error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// tb_weight_loader : table-driven frames with an event scoreboard
// Revision: 1.0
// ============================================================================
module tb_weight_loader;
  import dot_pkg::*;

  localparam int ROWS    = 3;
  localparam int COLS    = 4;
  localparam int NB      = ROWS * COLS;
  localparam int TIMEOUT = 200;
  localparam int NV      = 9;

  localparam logic [31:0] FP [NB] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000
  };

  typedef logic [0:ROWS-1][0:COLS-1][31:0] mat_t;
  typedef struct { bit is_err; mat_t m; } exp_t;
  typedef struct {
    int          nbeats;
    int          last_pos;
    bit          gaps;
    logic [31:0] seed;
    bit          exp_commit;
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        lock = 1'b0;
  mat_t        weights;
  logic        wvalid;
  logic        wupd;
  logic        lerr;

  int   checks = 0;
  int   errors = 0;
  int   n_commit = 0;
  exp_t sb_q[$];
  mat_t prev_w = '0;
  mat_t last_good = '0;

  always #5 clk = ~clk;

  weight_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk                (clk),
    .rst                (rst),
    .WEIGHT_AXIS_TDATA  (tdata),
    .WEIGHT_AXIS_TLAST  (tlast),
    .WEIGHT_AXIS_TVALID (tvalid),
    .WEIGHT_AXIS_TREADY (tready),
    .weights_lock       (lock),
    .weights            (weights),
    .weights_valid      (wvalid),
    .weights_updated    (wupd),
    .load_error         (lerr)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_mat(input string name, input mat_t act, input mat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic mat_t make_mat(input logic [31:0] seed);
    mat_t m;
    for (int i = 0; i < NB; i++) begin
      m[i / COLS][i % COLS] = (seed == 32'h0) ? FP[i] : (seed ^ (32'(i) * 32'h01000193));
    end
    return m;
  endfunction

  // Scoreboard: every commit/error pulse must match the next queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_w = weights;
      end else begin
        if (wupd || lerr) check32("upd_err_exclusive", {31'b0, wupd & lerr}, 32'h0);
        if (wupd) begin
          n_commit++;
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit actual=commit required=no_event");
          end else begin
            e = sb_q.pop_front();
            check32("event_kind_commit", {31'b0, e.is_err}, 32'h0);
            check_mat("commit_matrix", weights, e.m);
            check32("valid_after_commit", {31'b0, wvalid}, 32'h1);
          end
        end else begin
          check_mat("weights_stable_without_update", weights, prev_w);
        end
        if (lerr) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_load_error actual=error required=no_event");
          end else begin
            e = sb_q.pop_front();
            check32("event_kind_error", {31'b0, e.is_err}, 32'h1);
          end
        end
        prev_w = weights;
      end
    end
  end

  task automatic send_beats(input mat_t m, input int nbeats, input int last_pos, input bit gaps);
    int wait_cyc;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        tvalid = 1'b0;
        tdata  = $urandom;
        tlast  = 1'b1;
        @(negedge clk);
      end
      tvalid   = 1'b1;
      tdata    = (i < NB) ? m[i / COLS][i % COLS] : (32'hBAD00000 | 32'(i));
      tlast    = (i + 1 == last_pos);
      wait_cyc = 0;
      while (!tready && wait_cyc < TIMEOUT) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (!tready) begin
        checks++; errors++;
        $display("FAIL beat_accept_timeout actual=tready_low required=tready_high beat=%0d", i);
        tvalid = 1'b0;
        tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain_timeout actual=%0d required=0", sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    vec_t tv [NV];
    exp_t e;
    mat_t m;
    int   c0;
    int   bad;

    tv[0] = '{12, 12, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tv[1] = '{ 5,  5, 1'b0, 32'hA5A50000, 1'b0, 1'b1};
    tv[2] = '{12, 12, 1'b0, 32'h11110000, 1'b1, 1'b0};
    tv[3] = '{ 1,  1, 1'b0, 32'h22220000, 1'b0, 1'b1};
    tv[4] = '{14, 14, 1'b0, 32'h33330000, 1'b0, 1'b1};
    tv[5] = '{12, 12, 1'b0, 32'h44440000, 1'b1, 1'b0};
    tv[6] = '{12, 12, 1'b1, 32'h55550000, 1'b1, 1'b0};
    tv[7] = '{12, 12, 1'b1, 32'h66660000, 1'b1, 1'b0};
    tv[8] = '{12, 12, 1'b1, 32'h77770000, 1'b1, 1'b0};

    // Reset state, with TVALID asserted to show ready stays low
    tvalid = 1'b1;
    tdata  = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check32("rst_tready", {31'b0, tready}, 32'h0);
    check_mat("rst_weights", weights, '0);
    check32("rst_valid", {31'b0, wvalid}, 32'h0);
    check32("rst_updated", {31'b0, wupd}, 32'h0);
    check32("rst_error", {31'b0, lerr}, 32'h0);
    tvalid = 1'b0;
    #2 rst = 1'b1;
    #1 check32("tready_after_rst", {31'b0, tready}, 32'h1);
    @(negedge clk);

    // Commit latency: update visible one edge after the last beat
    m = make_mat(32'h0BAD0000);
    e.is_err = 1'b0; e.m = m; sb_q.push_back(e);
    send_beats(m, NB, NB, 1'b0);
    check32("commit_pending_tready", {31'b0, tready}, 32'h0);
    check32("no_early_update", {31'b0, wupd}, 32'h0);
    @(negedge clk);
    check32("update_latency", {31'b0, wupd}, 32'h1);
    check_mat("latency_matrix", weights, m);
    @(negedge clk);
    check32("update_single_pulse", {31'b0, wupd}, 32'h0);
    last_good = m;
    wait_drain();

    for (int v = 0; v < NV; v++) begin
      m  = make_mat(tv[v].seed);
      c0 = n_commit;
      if (tv[v].exp_err) begin
        e.is_err = 1'b1; e.m = '0; sb_q.push_back(e);
      end
      if (tv[v].exp_commit) begin
        e.is_err = 1'b0; e.m = m; sb_q.push_back(e);
        last_good = m;
      end
      send_beats(m, tv[v].nbeats, tv[v].last_pos, tv[v].gaps);
      wait_drain();
      check32($sformatf("vec%0d_commits", v), 32'(n_commit - c0), {31'b0, tv[v].exp_commit});
      check_mat($sformatf("vec%0d_live_matrix", v), weights, last_good);
      if (v == 0) begin
        check32("w23_float12", weights[2][3], 32'h41400000);
        check32("w00_float1", weights[0][0], 32'h3F800000);
        check32("valid_set", {31'b0, wvalid}, 32'h1);
      end
    end

    // Lock held 20 cycles after the last beat
    lock = 1'b1;
    m = make_mat(32'h10C40000);
    e.is_err = 1'b0; e.m = m; sb_q.push_back(e);
    send_beats(m, NB, NB, 1'b0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (tready !== 1'b0 || wupd !== 1'b0 || weights !== last_good) bad++;
      @(negedge clk);
    end
    check32("lock_hold_violations", 32'(bad), 32'h0);
    lock = 1'b0;
    @(negedge clk);
    check32("commit_after_unlock", {31'b0, wupd}, 32'h1);
    check_mat("unlock_matrix", weights, m);
    last_good = m;
    wait_drain();

    // Reset after seven beats discards the partial frame
    m = make_mat(32'h5E7E0000);
    send_beats(m, 7, 0, 1'b0);
    rst = 1'b0;
    #1;
    check_mat("midframe_rst_weights", weights, '0);
    check32("midframe_rst_valid", {31'b0, wvalid}, 32'h0);
    check32("midframe_rst_tready", {31'b0, tready}, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    m = make_mat(32'h600D0000);
    e.is_err = 1'b0; e.m = m; sb_q.push_back(e);
    send_beats(m, NB, NB, 1'b0);
    wait_drain();
    check_mat("post_rst_matrix", weights, m);
    check32("post_rst_valid", {31'b0, wvalid}, 32'h1);
    check32("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
